// File: rtl/sa_agree_btb_pkg.sv
// Shared types for the set-associative agree BTB.
// Tags are stored zero-extended to the widest possible tag.
package btb_pkg;

    localparam int TAG_MAX = 30;

    function automatic int tag_w(input int iw);
        return 30 - iw;
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    typedef struct packed {
        logic               valid;
        logic               bias;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
    } btb_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } flush_st_e;

endpackage

// File: rtl/sa_agree_btb_if.sv
// Lookup / update / flush bundle between the core and the BTB.
interface sa_agree_btb_if
    import btb_pkg::*;
#(
    parameter int INDEX_WIDTH = 6
) ();
    localparam int TAG_W = tag_w(INDEX_WIDTH);

    logic [INDEX_WIDTH-1:0] rd_index_i;
    logic [TAG_W-1:0]       rd_tag_i;
    logic                   hit_o;
    logic [31:0]            rd_target_o;
    logic                   bias_o;
    logic                   wren_i;
    logic [INDEX_WIDTH-1:0] wr_index_i;
    logic [TAG_W-1:0]       wr_tag_i;
    logic [31:0]            wr_target_i;
    logic                   br_taken_i;
    logic                   flush_i;
    logic                   busy_o;

    modport master (
        output rd_index_i, rd_tag_i,
        output wren_i, wr_index_i, wr_tag_i,
        output wr_target_i, br_taken_i, flush_i,
        input  hit_o, rd_target_o, bias_o, busy_o
    );

    modport slave (
        input  rd_index_i, rd_tag_i,
        input  wren_i, wr_index_i, wr_tag_i,
        input  wr_target_i, br_taken_i, flush_i,
        output hit_o, rd_target_o, bias_o, busy_o
    );

endinterface

// File: rtl/sa_agree_btb_victim_sel.sv
// Allocation way chooser: first invalid way, else the round-robin pointer.
module btb_victim_sel
    import btb_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int WW   = way_w(WAYS)
) (
    input  logic [WAYS-1:0] valid_i,
    input  logic [WW-1:0]   ptr_i,
    output logic [WW-1:0]   way_o,
    output logic            full_o
);

    always_comb begin
        way_o  = ptr_i;
        full_o = &valid_i;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                way_o = WW'(w);
            end
        end
    end

endmodule

// File: rtl/sa_agree_btb.sv
// Set-associative agree BTB with round-robin victims and a flush sequencer.
module sa_agree_btb
    import btb_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int WAYS        = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    sa_agree_btb_if.slave bus
);

    localparam int SETS  = 2 ** INDEX_WIDTH;
    localparam int TAG_W = tag_w(INDEX_WIDTH);
    localparam int WW    = way_w(WAYS);

    btb_entry_t       mem_q   [WAYS][SETS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WW-1:0]    ptr_q   [SETS];
    logic [WW-1:0]    ptr_d;
    flush_st_e        state_q;
    logic [INDEX_WIDTH-1:0] cnt_q;
    logic             busy_q;

    logic [TAG_MAX-1:0] rd_tag_x;
    logic [TAG_MAX-1:0] wr_tag_x;
    logic             rd_hit;
    logic [31:0]      rd_tgt;
    logic             rd_bias;
    logic             wr_hit;
    logic [WW-1:0]    wr_hit_way;
    logic [WW-1:0]    alloc_way;
    logic [WW-1:0]    wr_way;
    logic             set_full;
    logic             do_wr;

    assign rd_tag_x = TAG_MAX'(bus.rd_tag_i);
    assign wr_tag_x = TAG_MAX'(bus.wr_tag_i);

    // Descending scan so the lowest-numbered matching way wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_tgt  = '0;
        rd_bias = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[bus.rd_index_i][w] &&
                mem_q[w][bus.rd_index_i].tag == rd_tag_x) begin
                rd_hit  = 1'b1;
                rd_tgt  = mem_q[w][bus.rd_index_i].target;
                rd_bias = mem_q[w][bus.rd_index_i].bias;
            end
        end
    end

    assign bus.hit_o       = rd_hit & ~busy_q;
    assign bus.rd_target_o = bus.hit_o ? rd_tgt : 32'h0;
    assign bus.bias_o      = bus.hit_o & rd_bias;
    assign bus.busy_o      = busy_q;

    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[bus.wr_index_i][w] &&
                mem_q[w][bus.wr_index_i].tag == wr_tag_x) begin
                wr_hit     = 1'b1;
                wr_hit_way = WW'(w);
            end
        end
    end

    btb_victim_sel #(
        .WAYS (WAYS),
        .WW   (WW)
    ) u_victim (
        .valid_i (valid_q[bus.wr_index_i]),
        .ptr_i   (ptr_q[bus.wr_index_i]),
        .way_o   (alloc_way),
        .full_o  (set_full)
    );

    assign wr_way = wr_hit ? wr_hit_way : alloc_way;
    assign do_wr  = bus.wren_i & ~bus.flush_i &
                    (state_q == ST_IDLE);

    always_comb begin
        if (WAYS == 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_q[bus.wr_index_i] + WW'(1);
        end
    end

    // Payload storage is not reset; valid lives in the flops below.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            if (wr_hit) begin
                mem_q[wr_way][bus.wr_index_i].target <=
                    bus.wr_target_i;
            end else begin
                mem_q[wr_way][bus.wr_index_i] <= '{
                    valid:  1'b1,
                    bias:   bus.br_taken_i,
                    tag:    wr_tag_x,
                    target: bus.wr_target_i
                };
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.flush_i) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (do_wr) begin
                        valid_q[bus.wr_index_i][wr_way] <= 1'b1;
                        if (!wr_hit && set_full) begin
                            ptr_q[bus.wr_index_i] <= ptr_d;
                        end
                    end
                end
                ST_FLUSH: begin
                    valid_q[cnt_q] <= '0;
                    ptr_q[cnt_q]   <= '0;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == INDEX_WIDTH'(SETS - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_agree_btb.sv
// Directed self-checking bench for sa_agree_btb (INDEX_WIDTH=6, WAYS=2).
module tb_sa_agree_btb;

    localparam int IW = 6;
    localparam int TW = 30 - IW;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sa_agree_btb_if #(.INDEX_WIDTH(IW)) bus ();

    sa_agree_btb #(
        .INDEX_WIDTH (IW),
        .WAYS        (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        int          idx;
        logic [TW-1:0] tag;
        logic [31:0] tgt;
        bit          tk;
        bit          eh;
        logic [31:0] et;
        bit          eb;
        string       nm;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic void addw(input int idx, input logic [TW-1:0] tag,
                                 input logic [31:0] tgt, input bit tk);
        vec_t v;
        v.wr = 1; v.idx = idx; v.tag = tag; v.tgt = tgt; v.tk = tk;
        v.eh = 0; v.et = 0; v.eb = 0; v.nm = "wr";
        vq.push_back(v);
    endfunction

    function automatic void addl(input string nm, input int idx,
                                 input logic [TW-1:0] tag, input bit eh,
                                 input logic [31:0] et, input bit eb);
        vec_t v;
        v.wr = 0; v.idx = idx; v.tag = tag; v.tgt = 0; v.tk = 0;
        v.eh = eh; v.et = et; v.eb = eb; v.nm = nm;
        vq.push_back(v);
    endfunction

    task automatic do_write(input int idx, input logic [TW-1:0] tag,
                            input logic [31:0] tgt, input bit tk);
        @(negedge clk);
        bus.wren_i      = 1'b1;
        bus.wr_index_i  = IW'(idx);
        bus.wr_tag_i    = tag;
        bus.wr_target_i = tgt;
        bus.br_taken_i  = tk;
        @(posedge clk);
        #1;
        bus.wren_i = 1'b0;
    endtask

    task automatic look(input string nm, input int idx,
                        input logic [TW-1:0] tag, input bit eh,
                        input logic [31:0] et, input bit eb);
        bus.rd_index_i = IW'(idx);
        bus.rd_tag_i   = tag;
        #1;
        chk({nm, ".hit"}, 32'(bus.hit_o), 32'(eh));
        chk({nm, ".tgt"}, bus.rd_target_o, et);
        chk({nm, ".bias"}, 32'(bus.bias_o), 32'(eb));
    endtask

    task automatic wait_idle(input string nm, output int n);
        n = 0;
        while (bus.busy_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy_o) begin
            chk({nm, ".timeout"}, 32'(bus.busy_o), 32'd0);
        end
    endtask

    int n;

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.rd_index_i  = '0;
        bus.rd_tag_i    = '0;
        bus.wren_i      = 1'b0;
        bus.wr_index_i  = '0;
        bus.wr_tag_i    = '0;
        bus.wr_target_i = '0;
        bus.br_taken_i  = 1'b0;
        bus.flush_i     = 1'b0;
        #23;
        chk("rst.busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        addl("rst5", 5, 24'h100, 0, 0, 0);
        addl("rst0", 0, 24'h0, 0, 0, 0);
        addw(5, 24'h100, 32'h2000, 1);
        addl("hit1", 5, 24'h100, 1, 32'h2000, 1);
        addw(5, 24'h100, 32'h3000, 0);
        addl("agree", 5, 24'h100, 1, 32'h3000, 1);
        addl("otag", 5, 24'h101, 0, 0, 0);
        addl("oset", 6, 24'h100, 0, 0, 0);
        addw(3, 24'hA, 32'h1000, 0);
        addw(3, 24'hB, 32'h1100, 1);
        addl("A", 3, 24'hA, 1, 32'h1000, 0);
        addl("B", 3, 24'hB, 1, 32'h1100, 1);
        addw(3, 24'hC, 32'h1200, 1);
        addw(3, 24'hD, 32'h1300, 0);
        addl("C", 3, 24'hC, 1, 32'h1200, 1);
        addl("D", 3, 24'hD, 1, 32'h1300, 0);
        addl("Agone", 3, 24'hA, 0, 0, 0);
        addl("Bgone", 3, 24'hB, 0, 0, 0);
        addw(3, 24'hE, 32'h1400, 1);
        addl("E", 3, 24'hE, 1, 32'h1400, 1);
        addl("Cgone", 3, 24'hC, 0, 0, 0);
        addl("Dkeep", 3, 24'hD, 1, 32'h1300, 0);
        addw(63, 24'hFFFFFF, 32'hFFFF_FFFC, 1);
        addl("s63", 63, 24'hFFFFFF, 1, 32'hFFFF_FFFC, 1);
        addl("s5keep", 5, 24'h100, 1, 32'h3000, 1);

        foreach (vq[i]) begin
            if (vq[i].wr) begin
                do_write(vq[i].idx, vq[i].tag, vq[i].tgt, vq[i].tk);
            end else begin
                look(vq[i].nm, vq[i].idx, vq[i].tag,
                     vq[i].eh, vq[i].et, vq[i].eb);
            end
        end

        // Flush with an update injected into an already-cleared set.
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        chk("fl.busy_rise", 32'(bus.busy_o), 32'd1);
        n = 0;
        while (bus.busy_o && n < 200) begin
            if (n == 5) begin
                bus.wren_i      = 1'b1;
                bus.wr_index_i  = '0;
                bus.wr_tag_i    = 24'h77;
                bus.wr_target_i = 32'h7700;
                bus.br_taken_i  = 1'b1;
            end else begin
                bus.wren_i = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.wren_i = 1'b0;
        chk("fl.cycles", 32'(n), 32'd64);
        look("fl.inj", 0, 24'h77, 0, 0, 0);
        look("fl.s5", 5, 24'h100, 0, 0, 0);
        look("fl.D", 3, 24'hD, 0, 0, 0);
        look("fl.s63", 63, 24'hFFFFFF, 0, 0, 0);

        // Post-flush allocation must start again at way 0.
        do_write(3, 24'h31, 32'h3100, 0);
        do_write(3, 24'h32, 32'h3200, 0);
        do_write(3, 24'h33, 32'h3300, 1);
        look("rr.31", 3, 24'h31, 0, 0, 0);
        look("rr.32", 3, 24'h32, 1, 32'h3200, 0);
        look("rr.33", 3, 24'h33, 1, 32'h3300, 1);

        // Flush and write in the same cycle: flush wins.
        @(negedge clk);
        bus.flush_i     = 1'b1;
        bus.wren_i      = 1'b1;
        bus.wr_index_i  = IW'(9);
        bus.wr_tag_i    = 24'h99;
        bus.wr_target_i = 32'h9900;
        bus.br_taken_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.wren_i  = 1'b0;
        wait_idle("fw", n);
        chk("fw.cycles", 32'(n), 32'd64);
        look("fw.miss", 9, 24'h99, 0, 0, 0);

        // Reset in the middle of a flush.
        do_write(4, 24'h44, 32'h4400, 1);
        look("mr.pre", 4, 24'h44, 1, 32'h4400, 1);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        n = 0;
        while (n < 10) begin
            if (n == 1) begin
                look("mr.busymiss", 4, 24'h44, 0, 0, 0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("mr.busy10", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr.busy", 32'(bus.busy_o), 32'd0);
        look("mr.s4", 4, 24'h44, 0, 0, 0);
        look("mr.s3", 3, 24'h33, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        do_write(20, 24'h20, 32'h2020, 0);
        look("mr.fresh", 20, 24'h20, 1, 32'h2020, 0);
        chk("mr.idle", 32'(bus.busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_agree_btb.md
# sa_agree_btb

Set-associative, parametrised branch target buffer for the IF stage of the 5-stage pipeline, with per-entry agree bias bit. It extends the direct-mapped agree BTB to WAYS ways per set. Allocation fills an invalid way first, then falls back to a per-set round-robin victim. A multi-cycle flush sequencer lets the core invalidate the whole buffer on fence.i / context switch without a reset. Lookup is combinational against the current PC; update comes from EX on resolved branches.

## Interface
- INDEX_WIDTH, 6, set index bits (PC[INDEX_WIDTH+1:2]); SETS = 2**INDEX_WIDTH
- WAYS, 2, ways per set; power of two, 1..8
- TAG_W, 30-INDEX_WIDTH, derived: PC[31:INDEX_WIDTH+2]

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-high (the polarity and synchronicity are fixed)
- rd_index_i  in  INDEX_WIDTH  lookup set
- rd_tag_i  in  TAG_W  lookup tag
- hit_o  out  1  valid tag match in lookup set
- rd_target_o  out  32  target of hitting way; 0 when !hit_o
- bias_o  out  1  agree bias of hitting way; 0 when !hit_o
- wren_i  in  1  update request (one per resolved branch)
- wr_index_i  in  INDEX_WIDTH  update set
- wr_tag_i  in  TAG_W  update tag
- wr_target_i  in  32  resolved target
- br_taken_i  in  1  resolved direction
- flush_i  in  1  start full invalidation (level sampled when idle)
- busy_o  out  1  flush in progress

## Operation
- Lookup (combinational): compare rd_tag_i with all valid ways of set rd_index_i. If a way matches, hit_o=1 and the lowest-numbered matching way drives target and bias. Lookup is forced to a miss while busy_o=1.
- Update on a clock edge with wren_i=1 and FSM in IDLE:
  - tag hit in set: overwrite target with wr_target_i. Bias and victim pointer are unchanged; bias records the first outcome only (agree semantics).
  - miss: allocate the lowest-numbered invalid way. If none is invalid, allocate the way at the set's victim pointer, then advance the pointer by one modulo WAYS. The allocated way is written with valid=1, tag, target, bias=br_taken_i.
  - the update logic never creates duplicate tags within a set.
- Flush FSM, 2 states:
  - IDLE -> FLUSH when flush_i=1. The set counter loads 0.
  - In FLUSH, each cycle clears valid for all ways of set[counter] and resets that set's victim pointer to 0, then increments the counter.
  - FLUSH -> IDLE after the cycle that clears set SETS-1, so the flush takes exactly SETS cycles.
  - flush_i is ignored in FLUSH; wren_i is dropped (no write) in FLUSH.
- Simultaneous flush_i and wren_i in IDLE: flush wins and the update is dropped.
- Reset: all valid bits 0, victim pointers 0, FSM IDLE, counter 0. Outputs after reset: hit_o=0, rd_target_o=0, bias_o=0, busy_o=0. Target/tag/bias storage is not reset. Reset asserted mid-flush aborts the flush; all state returns to the reset values.

## Timing
- Lookup: 0-cycle (combinational from rd_* and state).
- Update visible to lookup in the cycle after the write edge. A same-cycle lookup on the written set sees the pre-write contents.
- busy_o rises the cycle after flush_i is sampled and stays high exactly SETS cycles.
- hit_o may be 0 for any set during those SETS cycles; it is guaranteed 0 for every set once busy_o falls, until the next write.
- Victim pointer advance is visible to the next allocation in the same set on the following edge.

## Structure
- Package btb_pkg:
  - TAG_W/way-index width helper functions
  - packed btb_entry_t {valid, bias, tag, target}
  - flush FSM state enum
- Sub-module btb_victim_sel: combinational priority encoder for the first invalid way. It falls back to the victim pointer input and outputs the allocation way index. The round-robin pointer registers stay in the top level.
- Storage: per-way arrays of btb_entry_t indexed by set; valid bits in flops for async clear.

## Test plan
- Reset then lookup any set -> hit_o=0, rd_target_o=0, bias_o=0, busy_o=0.
- Write set 5, tag 0x100, target 0x0000_2000, taken=1; next cycle look up set 5 / tag 0x100 -> hit_o=1, target 0x2000, bias_o=1. Rewrite the same tag with target 0x3000, taken=0 -> target 0x3000, bias_o stays 1.
- WAYS=2: allocate tags A, B, C, D into set 3 in sequence. C evicts way 0 and D evicts way 1, so lookups show C and D hit and A and B miss. Pointer wraps to 0.
- Pulse flush_i with INDEX_WIDTH=6 -> busy_o high exactly 64 cycles. A wren_i during the flush leaves no entry behind. All prior entries miss after the flush.
- flush_i and wren_i in the same cycle -> written tag misses after the flush completes.
- Assert rst_ni mid-flush (cycle 10) -> busy_o=0 immediately and all sets miss. A fresh write then hits the following cycle.
